// File: rtl/issue_queue_pkg.sv
// -----------------------------------------------------------------------------
// issue_queue_pkg
//   Shared definitions for the issue queue and the downstream age arbiter:
//   field widths, queue depth, opcode constants and the occupancy update rule.
// -----------------------------------------------------------------------------
package issue_queue_pkg;

    localparam int OPCODE_WIDTH = 7;
    localparam int AGE          = 5;
    localparam int TAG          = 6;
    localparam int DEPTH        = 16;
    localparam int IDX_W        = 4;
    localparam int CNT_W        = 5;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        R_TYPE = 7'b0110011,
        I_TYPE = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011
    } opcode_e;

    // Occupancy update: an allocate and an issue in the same cycle cancel out.
    function automatic logic [CNT_W-1:0] count_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] r;
        r = cnt;
        if (inc && !dec) begin
            r = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            r = cnt - CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/iq_free_pick.sv
// -----------------------------------------------------------------------------
// iq_free_pick
//   Lowest-index free slot finder for the issue queue.
//   Ports:
//     valid    in   DEPTH  per-slot valid bits
//     free_idx out  IDX_W  index of the lowest invalid slot (0 when full)
//     full     out  1      every slot is valid
// -----------------------------------------------------------------------------
module iq_free_pick
    import issue_queue_pkg::*;
(
    input  logic [DEPTH-1:0] valid,
    output logic [IDX_W-1:0] free_idx,
    output logic             full
);

    // Scan downward so the last hit, and therefore the result, is the lowest free slot.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full = &valid;

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//   16-entry out-of-order issue queue with dense age ordering, tag wakeup and
//   a registered issue payload.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     flush                         invalidate every entry (highest priority)
//     alloc_valid / alloc_ready     dispatch handshake
//     alloc_op, alloc_src1/2,
//     alloc_src1/2_rdy, alloc_dst   offered instruction
//     wb_valid, wb_tag              wakeup broadcast of a completed tag
//     iss_valid, iss_addr           grant from the age arbiter
//     op[], req[], age[]            per-entry view for the arbiter
//     out_valid, out_op,
//     out_src1/2, out_dst           payload of the entry issued last cycle
//     count                         number of valid entries (0..16)
// -----------------------------------------------------------------------------
module issue_queue
    import issue_queue_pkg::DEPTH;
    import issue_queue_pkg::IDX_W;
    import issue_queue_pkg::CNT_W;
    import issue_queue_pkg::count_next;
#(
    parameter int OPCODE_WIDTH = issue_queue_pkg::OPCODE_WIDTH,
    parameter int AGE          = issue_queue_pkg::AGE,
    parameter int TAG          = issue_queue_pkg::TAG
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,

    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic [OPCODE_WIDTH-1:0] alloc_op,
    input  logic [TAG-1:0]          alloc_src1,
    input  logic [TAG-1:0]          alloc_src2,
    input  logic                    alloc_src1_rdy,
    input  logic                    alloc_src2_rdy,
    input  logic [TAG-1:0]          alloc_dst,

    input  logic                    wb_valid,
    input  logic [TAG-1:0]          wb_tag,

    input  logic                    iss_valid,
    input  logic [IDX_W-1:0]        iss_addr,

    output logic [OPCODE_WIDTH-1:0] op  [DEPTH],
    output logic [DEPTH-1:0]        req,
    output logic [AGE-1:0]          age [DEPTH],

    output logic                    out_valid,
    output logic [OPCODE_WIDTH-1:0] out_op,
    output logic [TAG-1:0]          out_src1,
    output logic [TAG-1:0]          out_src2,
    output logic [TAG-1:0]          out_dst,

    output logic [CNT_W-1:0]        count
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] src1_rdy;
    logic [DEPTH-1:0] src2_rdy;
    logic [TAG-1:0]   src1 [DEPTH];
    logic [TAG-1:0]   src2 [DEPTH];
    logic [TAG-1:0]   dst  [DEPTH];

    logic [IDX_W-1:0] free_idx;
    logic             slots_full;
    logic             xfer;
    logic             iss_fire;
    logic [AGE-1:0]   iss_age;
    logic [CNT_W-1:0] new_age;
    logic             new_src1_rdy;
    logic             new_src2_rdy;

    iq_free_pick u_free_pick (
        .valid    (valid),
        .free_idx (free_idx),
        .full     (slots_full)
    );

    // Registered count only: a full queue stalls a cycle even while issuing.
    assign alloc_ready = (count != CNT_W'(DEPTH));

    assign req = valid & src1_rdy & src2_rdy;

    // slots_full mirrors count == 16; it also keeps a stray write off a live slot.
    assign xfer     = alloc_valid & alloc_ready & ~slots_full & ~flush;
    assign iss_fire = iss_valid & req[iss_addr] & ~flush;
    assign iss_age  = age[iss_addr];

    // Removing an entry closes its age gap, so the newcomer lands one lower.
    assign new_age = iss_fire ? (count - CNT_W'(1)) : count;

    // Same-cycle wakeup bypass into the allocating entry.
    assign new_src1_rdy = alloc_src1_rdy | (wb_valid & (alloc_src1 == wb_tag));
    assign new_src2_rdy = alloc_src2_rdy | (wb_valid & (alloc_src2 == wb_tag));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            src1_rdy  <= '0;
            src2_rdy  <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_src1  <= '0;
            out_src2  <= '0;
            out_dst   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i]  <= '0;
                op[i]   <= '0;
                src1[i] <= '0;
                src2[i] <= '0;
                dst[i]  <= '0;
            end
        end else if (flush) begin
            valid     <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid && valid[i] && (src1[i] == wb_tag)) begin
                    src1_rdy[i] <= 1'b1;
                end
                if (wb_valid && valid[i] && (src2[i] == wb_tag)) begin
                    src2_rdy[i] <= 1'b1;
                end
                if (iss_fire && valid[i] && (age[i] > iss_age)) begin
                    age[i] <= age[i] - AGE'(1);
                end
            end

            if (iss_fire) begin
                valid[iss_addr] <= 1'b0;
            end

            // The free slot is invalid, so the loop above never touched it.
            if (xfer) begin
                valid[free_idx]    <= 1'b1;
                op[free_idx]       <= alloc_op;
                src1[free_idx]     <= alloc_src1;
                src2[free_idx]     <= alloc_src2;
                dst[free_idx]      <= alloc_dst;
                src1_rdy[free_idx] <= new_src1_rdy;
                src2_rdy[free_idx] <= new_src2_rdy;
                age[free_idx]      <= AGE'(new_age);
            end

            count     <= count_next(count, xfer, iss_fire);
            out_valid <= iss_fire;
            if (iss_fire) begin
                out_op   <= op[iss_addr];
                out_src1 <= src1[iss_addr];
                out_src2 <= src2[iss_addr];
                out_dst  <= dst[iss_addr];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_issue_queue
//   Directed scenarios plus a randomized run against an age-ordered queue model:
//   an entry's age is simply its position in the model queue (oldest first).
// -----------------------------------------------------------------------------
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int OW = OPCODE_WIDTH;
    localparam int AW = AGE;
    localparam int TW = TAG;
    localparam int N  = DEPTH;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush;
    logic          alloc_valid, alloc_ready;
    logic [OW-1:0] alloc_op;
    logic [TW-1:0] alloc_src1, alloc_src2, alloc_dst;
    logic          alloc_src1_rdy, alloc_src2_rdy;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic          iss_valid;
    logic [3:0]    iss_addr;
    logic [OW-1:0] op  [N];
    logic [N-1:0]  req;
    logic [AW-1:0] age [N];
    logic          out_valid;
    logic [OW-1:0] out_op;
    logic [TW-1:0] out_src1, out_src2, out_dst;
    logic [4:0]    count;

    issue_queue #(.OPCODE_WIDTH(OW), .AGE(AW), .TAG(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
        .alloc_src1(alloc_src1), .alloc_src2(alloc_src2),
        .alloc_src1_rdy(alloc_src1_rdy), .alloc_src2_rdy(alloc_src2_rdy),
        .alloc_dst(alloc_dst), .wb_valid(wb_valid), .wb_tag(wb_tag),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .op(op), .req(req), .age(age),
        .out_valid(out_valid), .out_op(out_op), .out_src1(out_src1),
        .out_src2(out_src2), .out_dst(out_dst), .count(count)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int            slot;
        logic [OW-1:0] op;
        logic [TW-1:0] s1, s2, dst;
        bit            r1, r2;
    } ment_t;

    ment_t         mq[$];          // oldest first; position == age
    bit            m_ov;
    logic [OW-1:0] m_oop;
    logic [TW-1:0] m_os1, m_os2, m_odst;

    task automatic model_step();
        ment_t e;
        int    ip;
        int    slot;
        bit    used[N];
        bit    nalloc;
        if (!rst_n) begin
            mq.delete();
            m_ov = 0; m_oop = '0; m_os1 = '0; m_os2 = '0; m_odst = '0;
            return;
        end
        if (flush) begin
            mq.delete();
            m_ov = 0;
            return;
        end
        nalloc = alloc_valid && (mq.size() != N);
        ip = -1;
        if (iss_valid) begin
            foreach (mq[k]) if (mq[k].slot == int'(iss_addr) && mq[k].r1 && mq[k].r2) ip = k;
        end
        foreach (used[k]) used[k] = 0;
        foreach (mq[k]) used[mq[k].slot] = 1;
        slot = -1;
        for (int s = N - 1; s >= 0; s--) if (!used[s]) slot = s;
        if (wb_valid) begin
            foreach (mq[k]) begin
                e = mq[k];
                if (e.s1 == wb_tag) e.r1 = 1;
                if (e.s2 == wb_tag) e.r2 = 1;
                mq[k] = e;
            end
        end
        m_ov = (ip >= 0);
        if (ip >= 0) begin
            m_oop = mq[ip].op; m_os1 = mq[ip].s1; m_os2 = mq[ip].s2; m_odst = mq[ip].dst;
            mq.delete(ip);
        end
        if (nalloc) begin
            e.slot = slot; e.op = alloc_op; e.s1 = alloc_src1; e.s2 = alloc_src2; e.dst = alloc_dst;
            e.r1 = alloc_src1_rdy || (wb_valid && alloc_src1 == wb_tag);
            e.r2 = alloc_src2_rdy || (wb_valid && alloc_src2 == wb_tag);
            mq.push_back(e);
        end
    endtask

    function automatic int mpos(int s);
        int p;
        p = -1;
        foreach (mq[k]) if (mq[k].slot == s) p = k;
        return p;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush = 0; alloc_valid = 0; alloc_op = '0; alloc_src1 = '0; alloc_src2 = '0;
        alloc_src1_rdy = 0; alloc_src2_rdy = 0; alloc_dst = '0;
        wb_valid = 0; wb_tag = '0; iss_valid = 0; iss_addr = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    task automatic put_alloc(input logic [OW-1:0] o, input logic [TW-1:0] s1, input bit r1,
                             input logic [TW-1:0] s2, input bit r2, input logic [TW-1:0] d);
        alloc_valid = 1; alloc_op = o; alloc_src1 = s1; alloc_src1_rdy = r1;
        alloc_src2 = s2; alloc_src2_rdy = r2; alloc_dst = d;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h03);
        iss_valid = 1; iss_addr = 4'd0;
        cycle();
        cycle();
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
        n_vec++; if (req !== 16'h0) begin n_err++; $display("FAIL reset_req: got %h want 0", req); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if ({out_op, out_src1, out_src2, out_dst} !== '0) begin
            n_err++; $display("FAIL reset_payload: got %h %h %h %h want 0", out_op, out_src1, out_src2, out_dst);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++; if (age[i] !== '0) begin n_err++; $display("FAIL reset_age[%0d]: got %0d want 0", i, age[i]); end
        end
        rst_n = 1;
        idle();
    endtask

    task automatic test_first_alloc();
        do_reset();
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h03);
        n_vec++; if (req !== 16'h0) begin n_err++; $display("FAIL first_req_xfer_cycle: got %h want 0", req); end
        cycle();
        idle();
        n_vec++; if (req !== 16'h0001) begin n_err++; $display("FAIL first_req: got %h want 0001", req); end
        n_vec++; if (age[0] !== '0) begin n_err++; $display("FAIL first_age: got %0d want 0", age[0]); end
        n_vec++; if (op[0] !== R_TYPE) begin n_err++; $display("FAIL first_op: got %h want %h", op[0], R_TYPE); end
        n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL first_count: got %0d want 1", count); end
    endtask

    task automatic test_fill_issue();
        do_reset();
        for (int i = 0; i < N; i++) begin
            put_alloc(I_TYPE, TW'(i), 1, TW'(i + 16), 1, TW'(i));
            cycle();
        end
        idle();
        n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL fill_count: got %0d want 16", count); end
        n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", alloc_ready); end
        n_vec++; if (req !== 16'hFFFF) begin n_err++; $display("FAIL fill_req: got %h want ffff", req); end
        for (int i = 0; i < N; i++) begin
            n_vec++; if (age[i] !== AW'(i)) begin n_err++; $display("FAIL fill_age[%0d]: got %0d want %0d", i, age[i], i); end
        end
        put_alloc(STORE, 6'h3E, 1, 6'h3D, 1, 6'h3F);
        iss_valid = 1; iss_addr = 4'd5;
        n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_issue_ready: got %b want 0", alloc_ready); end
        cycle();
        idle();
        n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL issue5_count: got %0d want 15", count); end
        n_vec++; if (req !== 16'hFFDF) begin n_err++; $display("FAIL issue5_req: got %h want ffdf", req); end
        for (int i = 0; i < N; i++) begin
            if (i != 5) begin
                n_vec++;
                if (age[i] !== AW'(i < 5 ? i : i - 1)) begin
                    n_err++; $display("FAIL issue5_age[%0d]: got %0d want %0d", i, age[i], (i < 5 ? i : i - 1));
                end
            end
        end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL issue5_out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_dst !== 6'd5) begin n_err++; $display("FAIL issue5_out_dst: got %0d want 5", out_dst); end
        n_vec++; if (out_src2 !== 6'd21) begin n_err++; $display("FAIL issue5_out_src2: got %0d want 21", out_src2); end
        n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL issue5_ready: got %b want 1", alloc_ready); end
        cycle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL issue5_out_drop: got %b want 0", out_valid); end
        put_alloc(BRANCH, 6'h01, 1, 6'h02, 1, 6'h2A);
        cycle();
        idle();
        n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL refill_count: got %0d want 16", count); end
        n_vec++; if (age[5] !== AW'(15)) begin n_err++; $display("FAIL refill_age5: got %0d want 15", age[5]); end
        n_vec++; if (op[5] !== BRANCH) begin n_err++; $display("FAIL refill_op5: got %h want %h", op[5], BRANCH); end
    endtask

    task automatic test_wakeup_bypass();
        do_reset();
        put_alloc(R_TYPE, 6'h12, 0, 6'h03, 1, 6'h20);
        cycle();
        put_alloc(R_TYPE, 6'h13, 0, 6'h04, 1, 6'h21);
        cycle();
        idle();
        n_vec++; if (req !== 16'h0) begin n_err++; $display("FAIL wake_pre_req: got %h want 0", req); end
        wb_valid = 1; wb_tag = 6'h12;
        put_alloc(I_TYPE, 6'h05, 1, 6'h12, 0, 6'h22);
        cycle();
        idle();
        n_vec++; if (req !== 16'h0005) begin n_err++; $display("FAIL wake_req: got %h want 0005", req); end
        n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL wake_count: got %0d want 3", count); end
        wb_valid = 1; wb_tag = 6'h13;
        cycle();
        idle();
        n_vec++; if (req !== 16'h0007) begin n_err++; $display("FAIL wake2_req: got %h want 0007", req); end
    endtask

    task automatic test_alloc_issue_same();
        do_reset();
        put_alloc(LOAD, 6'h01, 1, 6'h02, 1, 6'h30); cycle();
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h31); cycle();
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h32); cycle();
        put_alloc(STORE, 6'h01, 1, 6'h02, 1, 6'h33);
        iss_valid = 1; iss_addr = 4'd0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ai_out_before: got %b want 0", out_valid); end
        cycle();
        idle();
        n_vec++; if (count !== 5'd3) begin n_err++; $display("FAIL ai_count: got %0d want 3", count); end
        n_vec++; if (age[3] !== AW'(2)) begin n_err++; $display("FAIL ai_new_age: got %0d want 2", age[3]); end
        n_vec++; if (age[1] !== AW'(0) || age[2] !== AW'(1)) begin
            n_err++; $display("FAIL ai_old_ages: got %0d,%0d want 0,1", age[1], age[2]);
        end
        n_vec++; if (req !== 16'h000E) begin n_err++; $display("FAIL ai_req: got %h want 000e", req); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ai_out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_dst !== 6'h30) begin n_err++; $display("FAIL ai_out_dst: got %h want 30", out_dst); end
        n_vec++; if (out_op !== LOAD) begin n_err++; $display("FAIL ai_out_op: got %h want %h", out_op, LOAD); end
    endtask

    task automatic test_bad_issue();
        logic [3:0] addrs [2];
        addrs[0] = 4'd0;
        addrs[1] = 4'd9;
        do_reset();
        put_alloc(R_TYPE, 6'h2A, 0, 6'h02, 1, 6'h10); cycle();
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h11); cycle();
        idle();
        for (int k = 0; k < 2; k++) begin
            iss_valid = 1; iss_addr = addrs[k];
            cycle();
            idle();
            n_vec++; if (count !== 5'd2) begin n_err++; $display("FAIL bad_iss%0d_count: got %0d want 2", k, count); end
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bad_iss%0d_out_valid: got %b want 0", k, out_valid); end
            n_vec++; if (req !== 16'h0002) begin n_err++; $display("FAIL bad_iss%0d_req: got %h want 0002", k, req); end
            n_vec++; if (age[0] !== AW'(0) || age[1] !== AW'(1)) begin
                n_err++; $display("FAIL bad_iss%0d_ages: got %0d,%0d want 0,1", k, age[0], age[1]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, TW'(i));
            cycle();
        end
        idle();
        n_vec++; if (count !== 5'd8) begin n_err++; $display("FAIL flush_pre_count: got %0d want 8", count); end
        flush = 1; iss_valid = 1; iss_addr = 4'd2; wb_valid = 1; wb_tag = 6'h01;
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h3F);
        cycle();
        idle();
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
        n_vec++; if (req !== 16'h0) begin n_err++; $display("FAIL flush_req: got %h want 0", req); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", alloc_ready); end
        put_alloc(I_TYPE, 6'h01, 1, 6'h02, 1, 6'h07);
        cycle();
        idle();
        n_vec++; if (req !== 16'h0001 || age[0] !== AW'(0)) begin
            n_err++; $display("FAIL flush_realloc: got req %h age %0d want 0001 age 0", req, age[0]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, TW'(i + 1));
            cycle();
        end
        iss_valid = 1; iss_addr = 4'd0;
        cycle();
        rst_n = 0;
        iss_valid = 1; iss_addr = 4'd1;
        put_alloc(R_TYPE, 6'h01, 1, 6'h02, 1, 6'h3C);
        cycle();
        rst_n = 1;
        idle();
        n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_vec++; if (req !== 16'h0) begin n_err++; $display("FAIL midrst_req: got %h want 0", req); end
        n_vec++; if (out_valid !== 1'b0 || out_dst !== '0) begin
            n_err++; $display("FAIL midrst_out: got valid %b dst %h want 0 0", out_valid, out_dst);
        end
    endtask

    task automatic test_random();
        int cands[$];
        int p;
        bit exp_req;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            flush          = ($urandom_range(0, 63) == 0);
            alloc_valid    = ($urandom_range(0, 9) < 6);
            alloc_op       = OW'($urandom);
            alloc_src1     = TW'($urandom_range(0, 7));
            alloc_src2     = TW'($urandom_range(0, 7));
            alloc_src1_rdy = ($urandom_range(0, 2) == 0);
            alloc_src2_rdy = ($urandom_range(0, 2) == 0);
            alloc_dst      = TW'($urandom);
            wb_valid       = ($urandom_range(0, 1) == 1);
            wb_tag         = TW'($urandom_range(0, 7));
            iss_valid      = ($urandom_range(0, 9) < 7);
            iss_addr       = 4'($urandom);
            cands.delete();
            foreach (mq[k]) if (mq[k].r1 && mq[k].r2) cands.push_back(mq[k].slot);
            if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                iss_addr = 4'(cands[$urandom_range(0, cands.size() - 1)]);
            end
            cycle();
            n_vec++; if (count !== 5'(mq.size())) begin
                n_err++; $display("FAIL rnd_count @%0d: got %0d want %0d", cyc, count, mq.size());
            end
            n_vec++; if (alloc_ready !== (mq.size() != N)) begin
                n_err++; $display("FAIL rnd_ready @%0d: got %b want %b", cyc, alloc_ready, (mq.size() != N));
            end
            for (int s = 0; s < N; s++) begin
                p = mpos(s);
                exp_req = (p >= 0) && mq[p].r1 && mq[p].r2;
                n_vec++; if (req[s] !== exp_req) begin
                    n_err++; $display("FAIL rnd_req[%0d] @%0d: got %b want %b", s, cyc, req[s], exp_req);
                end
                if (p >= 0) begin
                    n_vec++; if (age[s] !== AW'(p)) begin
                        n_err++; $display("FAIL rnd_age[%0d] @%0d: got %0d want %0d", s, cyc, age[s], p);
                    end
                    n_vec++; if (op[s] !== mq[p].op) begin
                        n_err++; $display("FAIL rnd_op[%0d] @%0d: got %h want %h", s, cyc, op[s], mq[p].op);
                    end
                end
            end
            n_vec++; if (out_valid !== m_ov) begin
                n_err++; $display("FAIL rnd_out_valid @%0d: got %b want %b", cyc, out_valid, m_ov);
            end
            if (m_ov) begin
                n_vec++; if ({out_op, out_src1, out_src2, out_dst} !== {m_oop, m_os1, m_os2, m_odst}) begin
                    n_err++; $display("FAIL rnd_payload @%0d: got %h %h %h %h want %h %h %h %h", cyc,
                                      out_op, out_src1, out_src2, out_dst, m_oop, m_os1, m_os2, m_odst);
                end
            end
        end
        rst_n = 1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_first_alloc();
        test_fill_issue();
        test_wakeup_bypass();
        test_alloc_issue_same();
        test_bad_issue();
        test_flush();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
